// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types and constants for the 1-bit serial link
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH       = 4;
    localparam bit LSB_FIRST_ORDER = 1'b1;
    localparam bit MSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - modulo-WIDTH bit counter with clear, enable and terminal count
module ser_bit_counter
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    // Clear wins over enable so a fresh word always starts at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with first/last frame markers
module piso_serializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit LSB_FIRST = LSB_FIRST_ORDER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    ser_state_t       state;
    ser_state_t       state_nx;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;
    logic             out_bit;

    // Ready also on the last-bit cycle so consecutive words stream without a gap.
    assign load_ready = (state == IDLE) || ((state == SHIFT) && tc);
    assign accept     = load_valid && load_ready;
    assign out_bit    = LSB_FIRST ? sr[0] : sr[WIDTH-1];

    ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == SHIFT),
        .cnt (cnt),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SHIFT;
            SHIFT:   if (accept) state_nx = SHIFT;
                     else if (tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (accept) begin
            sr <= pi;
        end else if (state == SHIFT) begin
            sr <= LSB_FIRST ? (sr >> 1) : (sr << 1);
        end
    end

    always_comb begin
        so_valid = (state == SHIFT);
        busy     = so_valid;
        so_first = so_valid && (cnt == '0);
        so_last  = so_valid && tc;
        so       = so_valid ? out_bit : 1'b0;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer in both bit orders
module tb_piso_serializer;
    import serial_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pi, pi_m;
    logic       load_valid, load_valid_m;
    logic       load_ready, so, so_valid, so_first, so_last, busy;
    logic       load_ready_m, so_m, so_valid_m, so_first_m, so_last_m, busy_m;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [2:0] q[$];
    logic [2:0] q_m[$];
    logic [2:0] e_l, e_m;
    logic [3:0] rx;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid), .load_ready(load_ready),
        .so(so), .so_valid(so_valid), .so_first(so_first), .so_last(so_last), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .pi(pi_m), .load_valid(load_valid_m), .load_ready(load_ready_m),
        .so(so_m), .so_valid(so_valid_m), .so_first(so_first_m), .so_last(so_last_m), .busy(busy_m)
    );

    // Receiver shifting in at its MSB toward bit 0, clocked on the same edges.
    always @(posedge clk or posedge rst) begin
        if (rst) rx <= 4'h0;
        else if (so_valid) rx <= {so, rx[3:1]};
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w, input bit msb_inst);
        logic b;
        for (int i = 0; i < 4; i++) begin
            b = msb_inst ? w[3-i] : w[i];
            if (msb_inst) q_m.push_back({b, i == 0, i == 3});
            else          q.push_back({b, i == 0, i == 3});
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {3'b0, so, so_valid, so_first, so_last, busy}, 8'h00);
    endtask

    // Walk one frame from its first-bit cycle; ready only on the last bit.
    task automatic frame_wait(input string tag);
        for (int k = 0; k < 4; k++) begin
            check(tag, {7'b0, load_ready}, {7'b0, k == 3});
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && so_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL lsb_extra_bit: observed so_valid 1 expected 0");
            end else begin
                e_l = q.pop_front();
                check("lsb_bit", {4'b0, so, so_first, so_last, busy}, {4'b0, e_l, 1'b1});
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && so_valid_m === 1'b1) begin
            if (q_m.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL msb_extra_bit: observed so_valid 1 expected 0");
            end else begin
                e_m = q_m.pop_front();
                check("msb_bit", {4'b0, so_m, so_first_m, so_last_m, busy_m}, {4'b0, e_m, 1'b1});
            end
        end
    end

    initial begin
        pi = 4'h0; load_valid = 1'b0; pi_m = 4'h0; load_valid_m = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1 check_idle("reset_async");
        check("reset_msb", {3'b0, so_m, so_valid_m, so_first_m, so_last_m, busy_m}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("ready_after_reset", {7'b0, load_ready}, 8'h01);

        // Single word 1011.
        pi = 4'b1011; load_valid = 1'b1; push_word(pi, 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        frame_wait("single_ready");
        check_idle("single_idle");
        check("single_drained", 8'(q.size()), 8'd0);

        // Back-to-back A then 3 with load_valid held.
        pi = 4'hA; load_valid = 1'b1;
        check("b2b_ready0", {7'b0, load_ready}, 8'h01);
        push_word(pi, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("b2b_ready1", {7'b0, load_ready}, {7'b0, k == 3});
            if (k == 3) begin
                pi = 4'h3;
                push_word(pi, 1'b0);
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        frame_wait("b2b_ready2");
        check_idle("b2b_idle");

        // Stall: F offered mid-frame of 0, taken on the last-bit edge.
        pi = 4'h0; load_valid = 1'b1; push_word(pi, 1'b0);
        @(negedge clk);
        pi = 4'hF;
        for (int k = 0; k < 4; k++) begin
            check("stall_ready", {7'b0, load_ready}, {7'b0, k == 3});
            if (k == 3) push_word(pi, 1'b0);
            @(negedge clk);
        end
        load_valid = 1'b0;
        frame_wait("stall_ready2");
        check_idle("stall_idle");

        // Reset after two bits of C aborts the word.
        pi = 4'hC; load_valid = 1'b1; push_word(pi, 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        q.delete();
        #1 check_idle("rst_mid_frame");
        @(negedge clk);
        rst = 1'b0;
        check("ready_after_rst_mid", {7'b0, load_ready}, 8'h01);
        pi = 4'h5; load_valid = 1'b1; push_word(pi, 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        frame_wait("post_rst_ready");
        check_idle("post_rst_idle");

        // Loopback into a receiver model.
        pi = 4'h9; load_valid = 1'b1; push_word(pi, 1'b0);
        @(negedge clk);
        load_valid = 1'b0;
        frame_wait("loop_ready");
        check("loopback_po", {4'b0, rx}, 8'h09);

        // MSB-first instance.
        pi_m = 4'b1000; load_valid_m = 1'b1;
        check("msb_ready", {7'b0, load_ready_m}, 8'h01);
        push_word(pi_m, 1'b1);
        @(negedge clk);
        load_valid_m = 1'b0;
        repeat (4) @(negedge clk);
        check("msb_idle", {3'b0, so_m, so_valid_m, so_first_m, so_last_m, busy_m}, 8'h00);

        check("lsb_sb_empty", 8'(q.size()), 8'd0);
        check("msb_sb_empty", 8'(q_m.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter: the sending end of the 1-bit serial link whose receiving end is the sipo_register deserializer. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock. It drives a bit-valid qualifier plus first/last frame markers. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
pi  input  WIDTH  parallel word to transmit.
load_valid  input  1  pi is valid and offered for transmission.
load_ready  output  1  serializer accepts pi this cycle; combinational.
so  output  1  serial data out.
so_valid  output  1  so carries a frame bit this cycle.
so_first  output  1  so carries the first bit of a word.
so_last  output  1  so carries the last bit of a word.
busy  output  1  same as so_valid; provided for status logic.

Behaviour:
- Reset is asynchronous and active-high. While rst = 1: shift register = 0, bit counter = 0, state = IDLE, so = 0, so_valid = 0, so_first = 0, so_last = 0, busy = 0. Reset mid-frame aborts the word immediately; remaining bits are never sent. After reset deasserts, the block is in IDLE and load_ready = 1.
- States:
  - IDLE: so_valid = 0.
  - SHIFT: so_valid = 1.
- Bit counter: cnt, width $clog2(WIDTH), counts 0..WIDTH-1 within the frame.
- load_ready = (state == IDLE) || (state == SHIFT && cnt == WIDTH-1). It is a pure function of registered state and does not depend on load_valid.
- Accept occurs on a rising edge where load_valid && load_ready:
  - pi is captured into the shift register.
  - cnt <= 0, state <= SHIFT.
- Latency: the first bit appears on so in the cycle immediately after the accept edge. The word then occupies exactly WIDTH consecutive so_valid cycles.
- Bit order:
  - LSB_FIRST = 1: so sequence is pi[0], pi[1], ..., pi[WIDTH-1].
  - LSB_FIRST = 0: so sequence is pi[WIDTH-1], ..., pi[0].
  - so is driven directly from the output end of the shift register, with no extra output stage.
- In SHIFT without an accept: each edge shifts the register by one bit toward the output end (vacated bit filled with 0) and increments cnt.
- On the edge where cnt == WIDTH-1:
  - If a new accept occurs on that edge, load the new word and reset cnt to 0. The next bit is the first bit of the new word, so the stream is gapless.
  - Otherwise go to IDLE.
- so_first = so_valid && cnt == 0; so_last = so_valid && cnt == WIDTH-1.
- In IDLE, so is held at 0.
- If load_valid is asserted while load_ready = 0, the word is not consumed. The shift register is untouched. The upstream source must hold pi and load_valid stable until load_ready.
- pi may change freely when not being accepted.
- Receiver compatibility: sipo_register shifts in at its MSB toward bit 0. With LSB_FIRST = 1, a receiver clocked on the same edges holds the complete word on its po after the WIDTH-th bit is sampled.

Decomposition:
- Shared package (serial_link_pkg) holds:
  - state enum (IDLE, SHIFT);
  - default width constant SER_WIDTH = 4;
  - bit-order constants LSB_FIRST_ORDER = 1 and MSB_FIRST_ORDER = 0.
- One natural sub-module: ser_bit_counter, a modulo-WIDTH counter with clear, enable and terminal-count flag. It is reusable by a future framed receiver.
- Shift register and FSM remain in the top module.

Test Plan:
- Reset: assert rst mid-cycle, asynchronously -> all outputs 0 immediately, with no clock edge needed; after release, load_ready = 1.
- Single word, WIDTH = 4, LSB_FIRST = 1, pi = 4'b1011 accepted -> so = 1,1,0,1 on the next 4 cycles; so_first on cycle 1; so_last on cycle 4; so_valid = 0 afterwards.
- Back-to-back: load_valid held high, words 4'hA then 4'h3 -> 8 contiguous valid bits 0,1,0,1,1,1,0,0; load_ready pulses high only on the last-bit cycle.
- Stall: offer 4'hF during cycles 2-3 of the frame for 4'h0 -> 4'h0 is sent intact, load_ready = 0 during those cycles, and 4'hF is accepted on the last-bit edge.
- Reset mid-frame: rst after 2 bits of 4'hC -> so_valid drops immediately; next accepted word 4'h5 sends 1,0,1,0 cleanly.
- Loopback and MSB-first:
  - LSB_FIRST = 1 driving sipo_register with pi = 4'h9 -> receiver po == 4'h9 after the 4th bit edge.
  - LSB_FIRST = 0 with pi = 4'b1000 -> so = 1,0,0,0.
